// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Streams a program, one byte at a time, into a 32-bit instruction memory.
//   The core is held in reset while loading and released after the last word.
//   Bytes are packed little-endian: the first byte of a word lands in bits[7:0].
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          load request and word count (sampled only in IDLE)
//   s_data, s_valid     incoming byte stream
//   s_ready             loader accepts a byte this cycle
//   mem_we, mem_addr,
//   mem_wdata           instruction-memory write port (byte address, word aligned)
//   cpu_rst_n           core reset, low while the core must be held
//   busy, done, err     status: loading, one-cycle completion pulse, sticky bad length
//   dbg_state           current FSM state, for observation only
//
// Handshake: a byte transfers on every rising edge where s_valid and s_ready
// are both 1. s_ready does not depend on s_valid, and s_data only needs to be
// stable while s_valid is 1.
module instr_mem_loader #(
    parameter int DEPTH = 128,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W:0] DEPTH_W = (LEN_W+1)'(DEPTH);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      wbuf;       // first three bytes of the word being assembled

    logic             len_zero;
    logic             len_over;
    logic [LEN_W:0]   idx_next;   // one bit wider so the final increment cannot wrap

    assign len_zero  = (len == '0);
    assign len_over  = ({1'b0, len} > DEPTH_W);
    assign idx_next  = {1'b0, word_idx} + {{LEN_W{1'b0}}, 1'b1};
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            wbuf      <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Pulsed outputs fall back to 0 unless a branch below raises them.
            done   <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_over) begin
                            // Refuse the request; the core reset is left as it was.
                            err <= 1'b1;
                        end else if (len_zero) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            len_q     <= len;
                            word_idx  <= '0;
                            byte_cnt  <= '0;
                            err       <= 1'b0;
                            cpu_rst_n <= 1'b0;
                            s_ready   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= RECV;
                        end
                    end
                end

                RECV: begin
                    // s_ready is always 1 here, so s_valid alone marks a transfer.
                    if (s_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {s_data, wbuf};
                            mem_addr  <= {{(30-LEN_W){1'b0}}, word_idx, 2'b00};
                            mem_we    <= 1'b1;
                            s_ready   <= 1'b0;
                            state     <= WRITE;
                        end else begin
                            wbuf[{byte_cnt, 3'b000} +: 8] <= s_data;
                        end
                    end
                end

                WRITE: begin
                    word_idx <= idx_next[LEN_W-1:0];
                    if (idx_next == {1'b0, len_q}) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                        state     <= DONE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= RECV;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader. Each load pushes the words it must
//   produce (address, assembled little-endian word) into exp_q; a compare
//   process pops them on every mem_we and checks the status outputs each cycle.
module tb_instr_mem_loader;

    localparam int DEPTH = 128;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             cpu_rst_n;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       dbg_state;

    instr_mem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wr_log[$];
    int          we_cnt = 0;
    int          last_we_cyc = 0;
    logic [31:0] hold_addr = '0;
    logic [31:0] hold_data = '0;
    int          in_load = 0;
    int          load_start_cyc = 0;
    int          load_done_cyc = 0;
    logic [7:0]  prog[0:511];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            hold_addr = '0;
            hold_data = '0;
            in_load   = 0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                wr_log.push_back({mem_addr, mem_wdata});
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h_%h expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {mem_addr, mem_wdata}, e);
                    hold_addr = e[63:32];
                    hold_data = e[31:0];
                end
            end else begin
                chk("addr_hold", 64'(mem_addr), 64'(hold_addr));
                chk("wdata_hold", 64'(mem_wdata), 64'(hold_data));
            end
            chk("busy_vs_phase", 64'(busy), 64'(s_ready | mem_we));
            chk("ready_we_excl", 64'(s_ready & mem_we), 64'(0));
            if (done) chk("done_not_busy", 64'(busy), 64'(0));
            if (busy && in_load == 0) begin
                in_load = 1;
                load_start_cyc = cyc;
            end
            if (done) begin
                in_load = 0;
                load_done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   t;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        rdy = 1'b0;
        t = 0;
        while (!rdy && t < 50) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
        if (!rdy) chk("byte_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_load(input int n, input int gap_max, input bit poke);
        int base_we;
        int s_edge;
        int t;
        wr_log.delete();
        base_we = we_cnt;
        for (int i = 0; i < n; i++)
            exp_q.push_back({32'(i * 4), prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]});
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk); #1;
        s_edge = cyc;
        start  = 1'b0;
        chk("load_cpu_held", 64'(cpu_rst_n), 64'(0));
        chk("load_busy", 64'(busy), 64'(1));
        chk("load_err_clear", 64'(err), 64'(0));
        for (int k = 0; k < 4 * n; k++) begin
            if (poke && k == 2) begin
                start = 1'b1;
                len   = LEN_W'(5);
                @(posedge clk); #1;
                start = 1'b0;
                len   = LEN_W'(n);
            end
            send_byte(prog[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        t = 0;
        forever begin
            @(negedge clk);
            if (done || t > 100) break;
            t++;
        end
        #1;
        if (!done) begin
            chk("done_timeout", 64'(0), 64'(1));
        end else begin
            if (gap_max == 0 && !poke)
                chk("load_cycles", 64'(load_done_cyc - load_start_cyc), 64'(5 * n));
            chk("first_ready_latency", 64'(load_start_cyc), 64'(s_edge));
            chk("done_after_write", 64'(load_done_cyc), 64'(last_we_cyc + 1));
            chk("write_count", 64'(we_cnt - base_we), 64'(n));
            chk("queue_empty", 64'(exp_q.size()), 64'(0));
            chk("cpu_released", 64'(cpu_rst_n), 64'(1));
            @(negedge clk);
            chk("done_pulse_width", 64'(done), 64'(0));
            chk("back_idle", 64'(dbg_state), 64'(0));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [7:0] p33[12];
        int base;
        int t;
        p33 = '{8'h93, 8'h04, 8'h00, 8'h00, 8'h13, 8'h04, 8'h00, 8'h00, 8'h93, 8'h02, 8'hA0, 8'h00};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_addr_data", {mem_addr, mem_wdata}, 64'(0));
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
        chk("rst_busy_done_err", {61'(0), busy, done, err}, 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Oversized length: error, nothing written, core stays held
        base = we_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(129);
        @(posedge clk); #1;
        start = 1'b0;
        chk("over_err", 64'(err), 64'(1));
        chk("over_idle", 64'(dbg_state), 64'(0));
        chk("over_not_ready", 64'({busy, s_ready}), 64'(0));
        chk("over_cpu_held", 64'(cpu_rst_n), 64'(0));
        repeat (3) @(negedge clk);
        chk("over_err_sticky", 64'(err), 64'(1));
        chk("over_no_write", 64'(we_cnt - base), 64'(0));

        // Zero length: done pulse right after the start edge, no write
        base = we_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        len   = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_cpu_release", 64'(cpu_rst_n), 64'(1));
        @(negedge clk);
        chk("zero_done_drop", 64'(done), 64'(0));
        chk("zero_no_write", 64'(we_cnt - base), 64'(0));

        // Three-word program with hand-computed words
        for (int i = 0; i < 12; i++) prog[i] = p33[i];
        do_load(3, 0, 1'b0);
        chk("lit_w0", wr_log[0], {32'h0000_0000, 32'h0000_0493});
        chk("lit_w1", wr_log[1], {32'h0000_0004, 32'h0000_0413});
        chk("lit_w2", wr_log[2], {32'h0000_0008, 32'h00A0_0293});

        // One word with random gaps on s_valid
        for (int i = 0; i < 4; i++) prog[i] = 8'(8'hC0 + i);
        do_load(1, 3, 1'b0);
        chk("lit_gap_word", wr_log[0], {32'h0, 32'hC3C2_C1C0});

        // start raised mid-load must be ignored
        for (int i = 0; i < 8; i++) prog[i] = 8'(8'h50 + 3 * i);
        do_load(2, 1, 1'b1);

        // Full-depth load, incrementing bytes
        for (int i = 0; i < 512; i++) prog[i] = 8'(i);
        do_load(DEPTH, 0, 1'b0);
        chk("lit_last_addr", 64'(wr_log[DEPTH-1][63:32]), 64'h1FC);
        chk("lit_last_word", 64'(wr_log[DEPTH-1][31:0]), 64'hFFFE_FDFC);

        // Reset after two of three words
        for (int i = 0; i < 12; i++) prog[i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 2; i++)
            exp_q.push_back({32'(i * 4), prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]});
        base = we_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) send_byte(prog[k], 0);
        t = 0;
        while (we_cnt < base + 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_two_written", 64'(we_cnt - base), 64'(2));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready_we", 64'({s_ready, mem_we}), 64'(0));
        chk("mid_rst_addr_data", {mem_addr, mem_wdata}, 64'(0));
        chk("mid_rst_status", 64'({cpu_rst_n, busy, done, err}), 64'(0));
        chk("mid_rst_state", 64'(dbg_state), 64'(0));
        chk("mid_queue_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_cpu_still_held", 64'(cpu_rst_n), 64'(0));
        for (int i = 0; i < 4; i++) prog[i] = 8'(8'hA0 + i);
        do_load(1, 0, 1'b0);
        chk("reload_addr0", wr_log[0], {32'h0, 32'hA3A2_A1A0});

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
